// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings for the E-stage mult/div issue controller:
// MD_* request-op codes, MUDI_* unit op codes and the FSM state encoding.
// Pure declarations; no logic, no latency, no flow control.
package md_issue_ctrl_pkg;

    // E-stage MD request opcodes; the low two bits of the arithmetic ops
    // line up with the MUDI_* codes so the unit op is a direct slice.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } md_req_op_e;

    typedef enum logic [1:0] {
        MUDI_MULT  = 2'd0,
        MUDI_MULTU = 2'd1,
        MUDI_DIV   = 2'd2,
        MUDI_DIVU  = 2'd3
    } mudi_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Ops that are sent to the unit (bit 2 clear).
    function automatic logic md_is_arith(input md_req_op_e op);
        return ~op[2];
    endfunction

    function automatic logic md_is_div(input md_req_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// Issue/stall controller in front of the mult/div unit; owns architectural HI/LO.
// Latency: md_start/md_op/md_a/md_b/stall/rd_data combinational; HI/LO/state update at the edge.
// Backpressure: stall=1 for any MD request while the unit is busy; unrelated instructions flow.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid, req_op         E-stage MD request and its MD_* opcode
//   rs_val, rt_val            forwarded operands
//   md_busy, md_hi, md_lo     status and result from the unit
//   md_start, md_op, md_a/b   issue pulse, MUDI_* op and operands to the unit
//   stall                     freeze F/D/E, bubble into M
//   rd_data                   MFHI/MFLO result, 0 when no MF op is active
//   md_err                    sticky flag: unit Busy did not match the expected latency
//
// Build option: MD_DIV0_BYPASS_EN -- DIV/DIVU with rt_val==0 is dropped instead of issued.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             md_busy,
    input  logic [WIDTH-1:0] md_hi,
    input  logic [WIDTH-1:0] md_lo,
    output logic             md_start,
    output logic [1:0]       md_op,
    output logic [WIDTH-1:0] md_a,
    output logic [WIDTH-1:0] md_b,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic             md_err
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    md_state_e        state_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [CW-1:0]    lat_q, lat_d;
    logic             err_q;

    md_req_op_e op;
    logic       idle;
    logic       div0_skip;
    logic       issue;

    assign op   = md_req_op_e'(req_op);
    assign idle = (state_q == ST_IDLE);

`ifdef MD_DIV0_BYPASS_EN
    assign div0_skip = md_is_div(op) && (rt_val == '0);
`else
    assign div0_skip = 1'b0;
`endif

    assign issue = ~rst && idle && req_valid && md_is_arith(op) && ~div0_skip;

    // Unit-facing outputs are held at zero unless a start is actually pulsed.
    assign md_start = issue;
    assign md_op    = issue ? req_op[1:0] : 2'b00;
    assign md_a     = issue ? rs_val : '0;
    assign md_b     = issue ? rt_val : '0;

    // Any MD request while BUSY is frozen in E, including in the completion
    // cycle; it is replayed in IDLE once HI/LO hold the unit result.
    assign stall = ~rst && ~idle && req_valid;

    always_comb begin
        rd_data = '0;
        if (~rst && idle && req_valid) begin
            if (op == MD_MFHI) rd_data = hi_q;
            if (op == MD_MFLO) rd_data = lo_q;
        end
    end

    assign md_err = err_q;

    // Latency counter: load on issue, count down per BUSY cycle, stick at 0.
    always_comb begin
        lat_d = (lat_q == '0) ? '0 : lat_q - CW'(1);
        if (issue) lat_d = md_is_div(op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else if (idle) begin
            // md_busy is not trusted here: the unit does not clear Busy on reset.
            if (issue) begin
                state_q <= ST_BUSY;
                lat_q   <= lat_d;
            end else if (req_valid && op == MD_MTHI) begin
                hi_q <= rs_val;
            end else if (req_valid && op == MD_MTLO) begin
                lo_q <= rs_val;
            end
        end else begin
            lat_q <= lat_d;
            // Busy drops one cycle after its last high cycle, by which point the
            // counter has already stepped from 1 to 0, so a correct completion
            // is seen here with lat_q==0; busy still high at lat_q==0 is overrun.
            if ((~md_busy && lat_q != '0) || (md_busy && lat_q == '0))
                err_q <= 1'b1;
            if (~md_busy) begin
                hi_q    <= md_hi;
                lo_q    <= md_lo;
                state_q <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;
    import md_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] rs_val, rt_val;
    logic        md_busy;
    logic [31:0] md_hi, md_lo;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] md_a, md_b;
    logic        stall;
    logic [31:0] rd_data;
    logic        md_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    md_issue_ctrl #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .rs_val(rs_val), .rt_val(rt_val), .md_busy(md_busy),
        .md_hi(md_hi), .md_lo(md_lo), .md_start(md_start), .md_op(md_op),
        .md_a(md_a), .md_b(md_b), .stall(stall), .rd_data(rd_data), .md_err(md_err)
    );

    // Behavioural mult/div unit: Busy high for the op latency starting the
    // cycle after Start, result valid from the first non-busy cycle.
    logic        use_model = 1'b0;
    logic        tb_busy   = 1'b0;
    int          u_cnt     = 0;
    logic [31:0] u_hi = '0, u_lo = '0;

    function automatic logic [63:0] unit_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'd0:    return sa * sb;
            2'd1:    return {32'b0, a} * {32'b0, b};
            2'd2:    return (b == 0) ? {a, 32'hFFFFFFFF} : {$signed(a) % $signed(b), $signed(a) / $signed(b)};
            default: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
        endcase
    endfunction

    always @(posedge clk) begin
        if (md_start) begin
            u_cnt <= md_op[1] ? 10 : 5;
            {u_hi, u_lo} <= unit_calc(md_op, md_a, md_b);
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
        end
    end

    assign md_busy = use_model ? (u_cnt != 0) : tb_busy;
    assign md_hi   = u_hi;
    assign md_lo   = u_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input md_req_op_e op, input logic [31:0] rs, input logic [31:0] rt);
        req_valid = vld;
        req_op    = op;
        rs_val    = rs;
        rt_val    = rt;
    endtask

    // Counts consecutive stalled cycles; returns at the negedge of the first non-stalled cycle.
    task automatic count_stalls(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            step();
        end
    endtask

    typedef struct {
        logic        vld;
        md_req_op_e  op;
        logic [31:0] rs;
        logic        busy;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];
    int   n;

    initial begin
        // Single-cycle IDLE vectors: MT writes, MF reads, md_busy noise ignored.
        vecs[0] = '{1'b1, MD_MFHI, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b1, MD_MTHI, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
        vecs[2] = '{1'b1, MD_MFHI, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, MD_MTLO, 32'h0000_0055, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, MD_MFLO, 32'h0000_0000, 1'b1, 32'h0000_0055};
        vecs[5] = '{1'b0, MD_MFLO, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[6] = '{1'b1, MD_MFHI, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF};
        vecs[7] = '{1'b1, MD_MTHI, 32'h0000_0001, 1'b1, 32'h0000_0000};
        vecs[8] = '{1'b1, MD_MFHI, 32'h0000_0000, 1'b0, 32'h0000_0001};
        vecs[9] = '{1'b1, MD_MFLO, 32'h0000_0000, 1'b1, 32'h0000_0055};

        rst = 1'b1;
        drive(1'b0, MD_MULT, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_start", {31'b0, md_start}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_rd", rd_data, 32'd0);
        chk("reset_err", {31'b0, md_err}, 32'd0);
        chk("reset_op_a", {30'b0, md_op} | md_a | md_b, 32'd0);
        step();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].vld, vecs[i].op, vecs[i].rs, 32'h0);
            tb_busy = vecs[i].busy;
            @(negedge clk);
            chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, 32'd0);
            chk($sformatf("vec%0d_start", i), {31'b0, md_start}, 32'd0);
            step();
        end
        tb_busy   = 1'b0;
        use_model = 1'b1;

        // 1: MULT 3 * -2, MFLO right behind it.
        drive(1'b1, MD_MULT, 32'd3, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("t1_start", {31'b0, md_start}, 32'd1);
        chk("t1_op", {30'b0, md_op}, 32'd0);
        chk("t1_a", md_a, 32'd3);
        chk("t1_b", md_b, 32'hFFFF_FFFE);
        chk("t1_stall_issue", {31'b0, stall}, 32'd0);
        step();
        drive(1'b1, MD_MFLO, 32'h0, 32'h0);
        count_stalls(n);
        chk("t1_stall_cycles", n, 32'd6);
        chk("t1_mflo", rd_data, 32'hFFFF_FFFA);
        step();
        drive(1'b1, MD_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        chk("t1_mfhi", rd_data, 32'hFFFF_FFFF);
        chk("t1_err", {31'b0, md_err}, 32'd0);
        step();

        // 2: DIVU 7 / 2.
        drive(1'b1, MD_DIVU, 32'd7, 32'd2);
        @(negedge clk);
        chk("t2_op", {30'b0, md_op}, 32'd3);
        step();
        drive(1'b1, MD_MFHI, 32'h0, 32'h0);
        count_stalls(n);
        chk("t2_stall_cycles", n, 32'd11);
        chk("t2_mfhi", rd_data, 32'd1);
        step();
        drive(1'b1, MD_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        chk("t2_mflo", rd_data, 32'd3);
        chk("t2_err", {31'b0, md_err}, 32'd0);
        step();

        // 3: MTHI then MFHI next cycle.
        drive(1'b1, MD_MTHI, 32'h1234, 32'h0);
        @(negedge clk);
        chk("t3_mthi_stall", {31'b0, stall}, 32'd0);
        step();
        drive(1'b1, MD_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        chk("t3_mfhi", rd_data, 32'h1234);
        chk("t3_mfhi_stall", {31'b0, stall}, 32'd0);
        step();

        // 4: MULT 5*6, independent instruction, then MFLO.
        drive(1'b1, MD_MULT, 32'd5, 32'd6);
        step();
        drive(1'b0, MD_MULT, 32'h0, 32'h0);
        @(negedge clk);
        chk("t4_add_stall", {31'b0, stall}, 32'd0);
        step();
        drive(1'b1, MD_MFLO, 32'h0, 32'h0);
        count_stalls(n);
        chk("t4_stall_cycles", n, 32'd5);
        chk("t4_mflo", rd_data, 32'd30);
        step();

        // 5: DIV by zero.
        drive(1'b1, MD_DIV, 32'd9, 32'd0);
        @(negedge clk);
`ifdef MD_DIV0_BYPASS_EN
        chk("t5_start", {31'b0, md_start}, 32'd0);
        chk("t5_stall", {31'b0, stall}, 32'd0);
        step();
        drive(1'b1, MD_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        chk("t5_mfhi", rd_data, 32'd0);
        chk("t5_mfhi_stall", {31'b0, stall}, 32'd0);
        step();
        drive(1'b1, MD_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        chk("t5_mflo", rd_data, 32'd30);
        step();
`else
        chk("t5_start", {31'b0, md_start}, 32'd1);
        step();
        drive(1'b1, MD_MFHI, 32'h0, 32'h0);
        count_stalls(n);
        chk("t5_stall_cycles", n, 32'd11);
        chk("t5_mfhi", rd_data, 32'd9);
        step();
`endif

        // MTLO stalled behind a MULT: unit result lands first, MT value wins.
        drive(1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd3);
        step();
        drive(1'b1, MD_MTLO, 32'h0000_00AB, 32'h0);
        count_stalls(n);
        chk("mt_stall_cycles", n, 32'd6);
        step();
        drive(1'b1, MD_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        chk("mt_mflo", rd_data, 32'h0000_00AB);
        step();
        drive(1'b1, MD_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        chk("mt_mfhi", rd_data, 32'hFFFF_FFFF);
        step();

        // 6: reset two cycles into a MULT.
        drive(1'b1, MD_MULT, 32'd4, 32'd4);
        step();
        drive(1'b0, MD_MULT, 32'h0, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, MD_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6_stall", {31'b0, stall}, 32'd0);
        chk("t6_lo", rd_data, 32'd0);
        step();
        drive(1'b1, MD_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6_hi", rd_data, 32'd0);
        step();
        drive(1'b0, MD_MULT, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) step();
        @(negedge clk);
        chk("t6_late_fall_err", {31'b0, md_err}, 32'd0);
        step();

        // Latency mismatch: Busy low on the first BUSY cycle.
        use_model = 1'b0;
        tb_busy   = 1'b0;
        drive(1'b1, MD_MULT, 32'd1, 32'd1);
        step();
        drive(1'b0, MD_MULT, 32'h0, 32'h0);
        @(negedge clk);
        chk("err_early_pre", {31'b0, md_err}, 32'd0);
        step();
        @(negedge clk);
        chk("err_early", {31'b0, md_err}, 32'd1);
        step();
        step();
        @(negedge clk);
        chk("err_sticky", {31'b0, md_err}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", {31'b0, md_err}, 32'd0);

        // Latency mismatch: Busy still high after the expected 5 cycles.
        tb_busy = 1'b1;
        drive(1'b1, MD_MULT, 32'd1, 32'd1);
        step();
        drive(1'b0, MD_MULT, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        chk("err_overrun_pre", {31'b0, md_err}, 32'd0);
        step();
        @(negedge clk);
        chk("err_overrun", {31'b0, md_err}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tb_busy = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
